// File: rtl/rca_bist_checker.sv
// BIST controller for a ripple-carry adder: sweeps every {cin, b, a} vector,
// checks {carryout, sum} against an internal reference and records the first failure.
module rca_bist_checker #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned NUM_VECTORS = 512
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic [WIDTH-1:0]     a,
   output logic [WIDTH-1:0]     b,
   output logic                 cin,
   input  logic [WIDTH-1:0]     sum,
   input  logic                 carryout,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2*WIDTH+1:0]   vec_count,
   output logic [15:0]          err_count,
   output logic                 fail_valid,
   output logic [WIDTH-1:0]     fail_a,
   output logic [WIDTH-1:0]     fail_b,
   output logic                 fail_cin
);

   localparam int unsigned VW  = 2*WIDTH + 1;
   localparam int unsigned VCW = 2*WIDTH + 2;
   localparam int unsigned EW  = 16;
   localparam int unsigned RW  = WIDTH + 1;
   localparam logic [VCW-1:0] LAST_VEC = VCW'(NUM_VECTORS - 1);

   typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_e;

   state_e            state_q, state_d;
   logic [VW-1:0]     v_q, v_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [VCW-1:0]    vec_count_q, vec_count_d;
   logic [EW-1:0]     err_count_q, err_count_d;
   logic              fail_valid_q, fail_valid_d;
   logic [WIDTH-1:0]  fail_a_q, fail_a_d;
   logic [WIDTH-1:0]  fail_b_q, fail_b_d;
   logic              fail_cin_q, fail_cin_d;

   logic [WIDTH-1:0]  cur_a, cur_b;
   logic              cur_cin;
   logic [RW-1:0]     exp_res;
   logic              mismatch;

   assign cur_a   = v_q[WIDTH-1:0];
   assign cur_b   = v_q[2*WIDTH-1:WIDTH];
   assign cur_cin = v_q[2*WIDTH];

   // Reference sum; operands zero-extended so the carry lands in the top bit
   assign exp_res  = RW'(cur_a) + RW'(cur_b) + RW'(cur_cin);
   assign mismatch = ({carryout, sum} != exp_res);

   always_comb begin
      state_d      = state_q;
      v_d          = v_q;
      busy_d       = busy_q;
      done_d       = done_q;
      pass_d       = pass_q;
      vec_count_d  = vec_count_q;
      err_count_d  = err_count_q;
      fail_valid_d = fail_valid_q;
      fail_a_d     = fail_a_q;
      fail_b_d     = fail_b_q;
      fail_cin_d   = fail_cin_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               v_d          = '0;
               busy_d       = 1'b1;
               done_d       = 1'b0;
               pass_d       = 1'b0;
               vec_count_d  = '0;
               err_count_d  = '0;
               fail_valid_d = 1'b0;
               fail_a_d     = '0;
               fail_b_d     = '0;
               fail_cin_d   = 1'b0;
               state_d      = APPLY;
            end
         end
         APPLY: begin
            state_d = CHECK;
         end
         CHECK: begin
            if (mismatch) begin
               if (err_count_q != '1) begin
                  err_count_d = err_count_q + EW'(1);
               end
               if (!fail_valid_q) begin
                  fail_valid_d = 1'b1;
                  fail_a_d     = cur_a;
                  fail_b_d     = cur_b;
                  fail_cin_d   = cur_cin;
               end
            end
            vec_count_d = vec_count_q + VCW'(1);
            if (vec_count_q == LAST_VEC) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_count_d == '0);
               state_d = DONE;
            end else begin
               v_d     = v_q + VW'(1);
               state_d = APPLY;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         v_q          <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         vec_count_q  <= '0;
         err_count_q  <= '0;
         fail_valid_q <= 1'b0;
         fail_a_q     <= '0;
         fail_b_q     <= '0;
         fail_cin_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         v_q          <= v_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         vec_count_q  <= vec_count_d;
         err_count_q  <= err_count_d;
         fail_valid_q <= fail_valid_d;
         fail_a_q     <= fail_a_d;
         fail_b_q     <= fail_b_d;
         fail_cin_q   <= fail_cin_d;
      end
   end

   assign a          = cur_a;
   assign b          = cur_b;
   assign cin        = cur_cin;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign vec_count  = vec_count_q;
   assign err_count  = err_count_q;
   assign fail_valid = fail_valid_q;
   assign fail_a     = fail_a_q;
   assign fail_b     = fail_b_q;
   assign fail_cin   = fail_cin_q;

endmodule

// File: tb/tb_rca_bist_checker.sv
// Bench for rca_bist_checker: behavioural adders with injectable faults, expected
// run results queued at start and checked by a monitor when done rises.
module tb_rca_bist_checker;

   typedef struct {
      string       name;
      int          done_cyc;
      logic [15:0] err;
      logic [9:0]  vec;
      logic        pass;
      logic        fv;
      logic [3:0]  fa;
      logic [3:0]  fb;
      logic        fc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT1: full exhaustive sweep
   logic        start1 = 1'b0;
   logic [3:0]  a1, b1, s1, fa1, fb1;
   logic        cin1, co1, busy1, done1, pass1, fv1, fc1;
   logic [9:0]  vec1;
   logic [15:0] err1;
   int          fault = 0;

   // DUT2: short five-vector run
   logic        start2 = 1'b0;
   logic [3:0]  a2, b2, s2, fa2, fb2;
   logic        cin2, co2, busy2, done2, pass2, fv2, fc2;
   logic [9:0]  vec2;
   logic [15:0] err2;

   rca_bist_checker #(.WIDTH(4), .NUM_VECTORS(512)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .sum(s1), .carryout(co1), .busy(busy1), .done(done1), .pass(pass1),
      .vec_count(vec1), .err_count(err1), .fail_valid(fv1), .fail_a(fa1),
      .fail_b(fb1), .fail_cin(fc1));

   rca_bist_checker #(.WIDTH(4), .NUM_VECTORS(5)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
      .sum(s2), .carryout(co2), .busy(busy2), .done(done2), .pass(pass2),
      .vec_count(vec2), .err_count(err2), .fail_valid(fv2), .fail_a(fa2),
      .fail_b(fb2), .fail_cin(fc2));

   // Adder models; fault 1 = sum[0] stuck at 0, fault 2 = carryout stuck at 0
   always_comb begin
      {co1, s1} = 5'(a1) + 5'(b1) + 5'(cin1);
      if (fault == 1) s1[0] = 1'b0;
      if (fault == 2) co1 = 1'b0;
   end

   always_comb begin
      {co2, s2} = 5'(a2) + 5'(b2) + 5'(cin2);
   end

   function automatic void chk(string nm, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endfunction

   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2;
   logic done1_prev = 1'b0;
   logic done2_prev = 1'b0;

   task automatic check_result(input exp_t e, input logic [15:0] err, input logic [9:0] vec,
                               input logic pass, input logic fv, input logic [3:0] fa,
                               input logic [3:0] fb, input logic fc);
      chk({e.name, " done_cycle"}, cyc, e.done_cyc);
      chk({e.name, " err_count"}, err, e.err);
      chk({e.name, " vec_count"}, vec, e.vec);
      chk({e.name, " pass"}, pass, e.pass);
      chk({e.name, " fail_valid"}, fv, e.fv);
      chk({e.name, " fail_a"}, fa, e.fa);
      chk({e.name, " fail_b"}, fb, e.fb);
      chk({e.name, " fail_cin"}, fc, e.fc);
   endtask

   // Monitor: pops an expectation whenever a DUT raises done
   always @(negedge clk) begin
      if (rst_n && done1 && !done1_prev) begin
         if (q1.size() == 0) chk("dut1 unexpected done", 1, 0);
         else begin
            e1 = q1.pop_front();
            check_result(e1, err1, vec1, pass1, fv1, fa1, fb1, fc1);
         end
      end
      if (rst_n && done2 && !done2_prev) begin
         if (q2.size() == 0) chk("dut2 unexpected done", 1, 0);
         else begin
            e2 = q2.pop_front();
            check_result(e2, err2, vec2, pass2, fv2, fa2, fb2, fc2);
         end
      end
      done1_prev = done1;
      done2_prev = done2;
   end

   task automatic start_run1(output int e0);
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      e0 = cyc;
      start1 = 1'b0;
   endtask

   task automatic push1(input string nm, input int e0, input int err, input logic pass,
                        input logic fv, input int fa, input int fb, input int fc);
      exp_t e;
      e.name = nm; e.done_cyc = e0 + 1024; e.err = 16'(err); e.vec = 10'd512;
      e.pass = pass; e.fv = fv; e.fa = 4'(fa); e.fb = 4'(fb); e.fc = 1'(fc);
      q1.push_back(e);
   endtask

   task automatic wait_q1(input string nm);
      for (int i = 0; i < 1200 && q1.size() != 0; i++) @(negedge clk);
      if (q1.size() != 0) begin
         chk({nm, " timeout waiting for done"}, 0, 1);
         q1.delete();
      end
   endtask

   initial begin
      int e0;
      exp_t e;

      // Reset values
      #1;
      chk("reset a", a1, 0);
      chk("reset b", b1, 0);
      chk("reset cin", cin1, 0);
      chk("reset busy", busy1, 0);
      chk("reset done", done1, 0);
      chk("reset pass", pass1, 0);
      chk("reset vec_count", vec1, 0);
      chk("reset err_count", err1, 0);
      chk("reset fail_valid", fv1, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Correct adder, full sweep
      fault = 0;
      start_run1(e0);
      chk("run0 busy after start", busy1, 1);
      chk("run0 vector0 a", a1, 0);
      push1("good", e0, 0, 1'b1, 1'b0, 0, 0, 0);
      wait_q1("good");

      // sum[0] stuck at 0
      fault = 1;
      start_run1(e0);
      push1("sum0", e0, 256, 1'b0, 1'b1, 1, 0, 0);
      wait_q1("sum0");

      // carryout stuck at 0: 120 + 136 failing vectors
      fault = 2;
      start_run1(e0);
      push1("cout", e0, 256, 1'b0, 1'b1, 15, 1, 0);
      wait_q1("cout");
      repeat (3) @(negedge clk);
      chk("done held after run", done1, 1);
      chk("start ignored when idle low, err held", err1, 256);

      // Restart with adder fixed: results clear
      fault = 0;
      start_run1(e0);
      chk("restart done cleared", done1, 0);
      chk("restart vec_count cleared", vec1, 0);
      chk("restart err_count cleared", err1, 0);
      chk("restart fail_valid cleared", fv1, 0);
      chk("restart fail_a cleared", fa1, 0);
      chk("restart busy", busy1, 1);
      push1("restart", e0, 0, 1'b1, 1'b0, 0, 0, 0);
      wait_q1("restart");

      // Mid-run reset at E0+301
      start_run1(e0);
      while (cyc < e0 + 300) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst busy", busy1, 0);
      chk("midrst vec_count", vec1, 0);
      chk("midrst a", a1, 0);
      chk("midrst b", b1, 0);
      chk("midrst done", done1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("after reset idle busy", busy1, 0);
      chk("after reset idle a", a1, 0);
      while (cyc < e0 + 1100) @(negedge clk);
      chk("midrst done never", done1, 0);
      chk("midrst vec_count stays 0", vec1, 0);

      // Short run, start held for three cycles
      @(negedge clk);
      start2 = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k == 0) begin
            e0 = cyc;
            e.name = "n5"; e.done_cyc = e0 + 10; e.err = 16'd0; e.vec = 10'd5;
            e.pass = 1'b1; e.fv = 1'b0; e.fa = 4'd0; e.fb = 4'd0; e.fc = 1'b0;
            q2.push_back(e);
         end
         if (k == 2) start2 = 1'b0;
         if (k % 2 == 0) begin
            chk($sformatf("n5 a step%0d", k / 2), a2, k / 2);
            chk($sformatf("n5 b step%0d", k / 2), b2, 0);
            chk($sformatf("n5 cin step%0d", k / 2), cin2, 0);
         end
      end
      for (int i = 0; i < 20 && q2.size() != 0; i++) @(negedge clk);
      if (q2.size() != 0) begin
         chk("n5 timeout waiting for done", 0, 1);
         q2.delete();
      end
      repeat (2) @(negedge clk);
      chk("n5 a holds last vector", a2, 4);
      chk("n5 done held", done2, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
